demux4_frame_assembler: RTL and testbench



---
 rtl/demux4_frame_assembler.sv | 67 ++++++
 tb/tb_demux4_frame_assembler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux4_frame_assembler.sv
// Steers a stream of B-bit words into four lane registers and offers the completed frame downstream.
// The frame is valid the cycle after the 4th accept; in HOLD the input stalls until out_ready takes the frame.
module demux4_frame_assembler #(
  parameter int B = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [B-1:0]        in_data,
  input  logic                in_valid,
  input  logic                in_first,
  output logic                in_ready,
  output logic [3:0][B-1:0]   out_frame,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          drop_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t     state;
  logic [1:0] idx;

  // Held low while reset is asserted so nothing upstream mistakes a reset cycle for an accept.
  assign in_ready = (state == FILL) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      idx        <= 2'd0;
      out_frame  <= '0;
      out_valid  <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (in_first && idx != 2'd0) begin
              // Resync: lanes 1..3 keep stale data; they are rewritten before the frame completes.
              out_frame[0] <= in_data;
              idx          <= 2'd1;
              if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            end else begin
              out_frame[idx] <= in_data;
              idx            <= idx + 2'd1;
              if (idx == 2'd3) begin
                state     <= HOLD;
                out_valid <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= FILL;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux4_frame_assembler.sv
// Randomised and directed stimulus for the 4-lane frame assembler with a queue-based reference.
module tb_demux4_frame_assembler;

  localparam int B = 64;
  typedef logic [3:0][B-1:0] frame_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [B-1:0]     in_data;
  logic             in_valid;
  logic             in_first;
  logic             in_ready;
  frame_t           out_frame;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       drop_count;

  demux4_frame_assembler #(.B(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_first   (in_first),
    .in_ready   (in_ready),
    .out_frame  (out_frame),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  bit chk_en = 1'b0;

  // Reference: words collected for the frame in progress, completed frames awaiting delivery.
  logic [B-1:0] partial[$];
  frame_t       exp_q[$];
  bit           m_hold = 1'b0;
  int           m_drops = 0;
  bit           m_zero = 1'b1;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 256'(in_ready), 256'(!m_hold && !reset));
      check("out_valid", 256'(out_valid), 256'(m_hold));
      check("drop_count", 256'(drop_count), 256'(m_drops));
      if (m_hold && exp_q.size() > 0)
        check("out_frame", out_frame, exp_q[0]);
      if (m_zero)
        check("out_frame_cleared", out_frame, 256'd0);

      // Advance the reference across the coming rising edge.
      if (reset) begin
        m_hold  = 1'b0;
        m_drops = 0;
        m_zero  = 1'b1;
        partial.delete();
        exp_q.delete();
      end else if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          frames_seen++;
        end
      end else if (in_valid) begin
        m_zero = 1'b0;
        if (in_first && partial.size() != 0) begin
          if (m_drops < 255) m_drops++;
          partial.delete();
        end
        partial.push_back(in_data);
        if (partial.size() == 4) begin
          frame_t f;
          for (int k = 0; k < 4; k++) f[k] = partial[k];
          exp_q.push_back(f);
          partial.delete();
          m_hold = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic f, input logic [B-1:0] d,
                     input logic r, input logic rs = 1'b0);
    @(posedge clk);
    #1;
    reset     = rs;
    in_valid  = v;
    in_first  = f;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic idle(input int n, input logic r = 1'b1);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, r);
  endtask

  task automatic rst(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    rst(2);

    // Basic frame
    cyc(1, 1, 64'h11, 1);
    cyc(1, 0, 64'h22, 1);
    cyc(1, 0, 64'h33, 1);
    cyc(1, 0, 64'h44, 1);
    idle(3);

    // Back-pressure, with words offered during HOLD that must be ignored
    cyc(1, 1, 64'h5151, 0);
    cyc(1, 0, 64'h5252, 0);
    cyc(1, 0, 64'h5353, 0);
    cyc(1, 0, 64'h5454, 0);
    for (int i = 0; i < 6; i++) cyc(1, (i == 2), 64'hDEAD_0000 + 64'(i), 0);
    cyc(1, 1, 64'hBEEF, 1);
    idle(2);

    // Resync
    cyc(1, 1, 64'hA0, 1);
    cyc(1, 0, 64'hA1, 1);
    cyc(1, 1, 64'hB0, 1);
    cyc(1, 0, 64'hB1, 1);
    cyc(1, 0, 64'hB2, 1);
    cyc(1, 0, 64'hB3, 1);
    idle(2);

    // Valid gaps
    for (int i = 0; i < 8; i++) cyc(i[0] == 0, i == 0, 64'hC0 + 64'(i), 1);
    idle(2);

    // Saturation: 301 first-marked words give 300 resyncs
    for (int i = 0; i < 301; i++) cyc(1, 1, 64'(i), 1);
    cyc(1, 0, 64'hE1, 1);
    cyc(1, 0, 64'hE2, 1);
    cyc(1, 0, 64'hE3, 1);
    idle(2);

    // Reset after two accepts, then a clean frame
    cyc(1, 1, 64'hF0, 1);
    cyc(1, 0, 64'hF1, 1);
    rst(1);
    idle(1);
    for (int i = 0; i < 4; i++) cyc(1, i == 0, 64'h70 + 64'(i), 1);
    idle(2);

    // Reset while in HOLD, then a clean frame
    for (int i = 0; i < 4; i++) cyc(1, i == 0, 64'h80 + 64'(i), 0);
    idle(2, 0);
    rst(1);
    idle(1);
    for (int i = 0; i < 4; i++) cyc(1, i == 0, 64'h90 + 64'(i), 1);
    idle(2);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          {$urandom, $urandom}, $urandom_range(0, 2) != 0,
          $urandom_range(0, 199) == 0);
    idle(4);

    checks++;
    if (frames_seen < 12) begin
      errors++;
      $display("FAIL frames_delivered got %0d want at least 12", frames_seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
